// File: rtl/sdu_pkg.sv
// Shared definitions for the SDU loader: command codes, response bytes, FSM states.
package sdu_pkg;

  localparam logic [7:0] CMD_WR_IM = 8'h01;
  localparam logic [7:0] CMD_WR_DM = 8'h02;
  localparam logic [7:0] CMD_RD_IM = 8'h03;
  localparam logic [7:0] CMD_RD_DM = 8'h04;
  localparam logic [7:0] CMD_RD_RF = 8'h05;
  localparam logic [7:0] CMD_STEP  = 8'h10;
  localparam logic [7:0] CMD_RUN   = 8'h11;
  localparam logic [7:0] CMD_HALT  = 8'h12;

  localparam logic [7:0] ACK_MASK = 8'h80;
  localparam logic [7:0] NAK      = 8'hEE;

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StWrSetup,
    StWrStrobe,
    StWrHold,
    StRdWait,
    StTxResp,
    StStepPulse
  } sdu_state_e;

  function automatic logic cmd_has_addr(input logic [7:0] cmd);
    return (cmd >= CMD_WR_IM) && (cmd <= CMD_RD_RF);
  endfunction

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return (cmd == CMD_WR_IM) || (cmd == CMD_WR_DM);
  endfunction

  // Single-byte responses are left-aligned so the serialiser always sends from the top.
  function automatic logic [31:0] resp_byte(input logic [7:0] b);
    return {b, 24'h000000};
  endfunction

endpackage

// File: rtl/sdu_loader_if.sv
// Host byte streams plus the CPU load/debug bus of the SDU loader.
interface sdu_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we_im;
  logic        we_dm;
  logic        clk_ld;
  logic        debug;
  logic [31:0] dout_im;
  logic [31:0] dout_dm;
  logic [31:0] dout_rf;
  logic        cpu_clk_en;

  modport master (
    output rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf,
    input  rx_ready, tx_data, tx_valid, addr, din, we_im, we_dm, clk_ld, debug, cpu_clk_en
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf,
    output rx_ready, tx_data, tx_valid, addr, din, we_im, we_dm, clk_ld, debug, cpu_clk_en
  );
endinterface

// File: rtl/sdu_tx_ser.sv
// Shifts a 1- or 4-byte response out MSB first over a valid/ready byte handshake.
module sdu_tx_ser (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_load,
  input  logic        i_one,
  input  logic [31:0] i_word,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_done
);
  logic [31:0] r_buf;
  logic [2:0]  r_left;
  logic        w_fire;

  assign o_valid = (r_left != 3'd0);
  assign o_data  = r_buf[31:24];
  assign w_fire  = o_valid && i_ready;
  assign o_done  = w_fire && (r_left == 3'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf  <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_buf  <= i_word;
      r_left <= i_one ? 3'd1 : 3'd4;
    end else if (w_fire) begin
      r_buf  <= {r_buf[23:0], 8'h00};
      r_left <= r_left - 3'd1;
    end
  end
endmodule

// File: rtl/sdu_loader.sv
// Host command decoder that loads/reads CPU memories and controls run/halt/step.
module sdu_loader
  import sdu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input logic         clk,
  input logic         rstn,
  sdu_loader_if.slave bus
);
  sdu_state_e  r_state, w_state_d;
  logic [7:0]  r_cmd, w_cmd_d;
  logic [15:0] r_addr, w_addr_d;
  logic [31:0] r_data, w_data_d;
  logic [1:0]  r_cnt, w_cnt_d;
  logic [31:0] r_gap, w_gap_d;
  logic        r_run, w_run_d;
  logic        r_live;
  logic        w_rx_ready, w_rx_fire, w_gap_hit, w_wr_phase;
  logic        w_tx_load, w_tx_one, w_tx_done, w_tx_valid;
  logic [31:0] w_tx_word;
  logic [7:0]  w_tx_data;

  // r_live keeps rx_ready low until the first edge after reset release.
  assign w_rx_ready = r_live && (r_state inside {StIdle, StGetAddr, StGetData});
  assign w_rx_fire  = w_rx_ready && bus.rx_valid;
  assign w_gap_hit  = (r_gap == TIMEOUT_CYC - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_run   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cmd   <= w_cmd_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
      r_cnt   <= w_cnt_d;
      r_gap   <= w_gap_d;
      r_run   <= w_run_d;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cmd_d   = r_cmd;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    w_cnt_d   = r_cnt;
    w_gap_d   = r_gap;
    w_run_d   = r_run;
    w_tx_load = 1'b0;
    w_tx_one  = 1'b1;
    w_tx_word = '0;
    unique case (r_state)
      StIdle: begin
        w_gap_d = '0;
        if (w_rx_fire) begin
          w_cmd_d = bus.rx_data;
          w_cnt_d = '0;
          if (cmd_has_addr(bus.rx_data)) begin
            w_state_d = StGetAddr;
          end else begin
            w_state_d = StTxResp;
            w_tx_load = 1'b1;
            w_tx_word = resp_byte(bus.rx_data | ACK_MASK);
            case (bus.rx_data)
              CMD_RUN:  w_run_d = 1'b1;
              CMD_HALT: w_run_d = 1'b0;
              CMD_STEP: begin
                if (!r_run) begin
                  w_state_d = StStepPulse;
                  w_tx_load = 1'b0;
                end
              end
              default:  w_tx_word = resp_byte(NAK);
            endcase
          end
        end
      end
      StGetAddr: begin
        if (w_rx_fire) begin
          w_gap_d  = '0;
          w_addr_d = {r_addr[7:0], bus.rx_data};
          w_cnt_d  = r_cnt + 2'd1;
          if (r_cnt == 2'd1) begin
            w_cnt_d = '0;
            if (cmd_is_write(r_cmd)) begin
              w_state_d = StGetData;
            end else if (r_run && (r_cmd != CMD_RD_RF)) begin
              w_state_d = StTxResp;
              w_tx_load = 1'b1;
              w_tx_word = resp_byte(NAK);
            end else begin
              w_state_d = StRdWait;
            end
          end
        end else if (w_gap_hit) begin
          w_state_d = StIdle;
        end else begin
          w_gap_d = r_gap + 32'd1;
        end
      end
      StGetData: begin
        if (w_rx_fire) begin
          w_gap_d  = '0;
          w_data_d = {r_data[23:0], bus.rx_data};
          w_cnt_d  = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            if (r_run) begin
              w_state_d = StTxResp;
              w_tx_load = 1'b1;
              w_tx_word = resp_byte(NAK);
            end else begin
              w_state_d = StWrSetup;
            end
          end
        end else if (w_gap_hit) begin
          w_state_d = StIdle;
        end else begin
          w_gap_d = r_gap + 32'd1;
        end
      end
      StWrSetup:  w_state_d = StWrStrobe;
      StWrStrobe: w_state_d = StWrHold;
      StWrHold: begin
        w_state_d = StTxResp;
        w_tx_load = 1'b1;
        w_tx_word = resp_byte(r_cmd | ACK_MASK);
      end
      StRdWait: begin
        w_state_d = StTxResp;
        w_tx_load = 1'b1;
        w_tx_one  = 1'b0;
        case (r_cmd)
          CMD_RD_IM: w_tx_word = bus.dout_im;
          CMD_RD_DM: w_tx_word = bus.dout_dm;
          default:   w_tx_word = bus.dout_rf;
        endcase
      end
      StTxResp: begin
        if (w_tx_done) w_state_d = StIdle;
      end
      StStepPulse: begin
        w_state_d = StTxResp;
        w_tx_load = 1'b1;
        w_tx_word = resp_byte(CMD_STEP | ACK_MASK);
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_wr_phase     = r_state inside {StWrSetup, StWrStrobe, StWrHold};
    bus.rx_ready   = w_rx_ready;
    bus.we_im      = w_wr_phase && (r_cmd == CMD_WR_IM);
    bus.we_dm      = w_wr_phase && (r_cmd == CMD_WR_DM);
    bus.clk_ld     = (r_state == StWrStrobe);
    bus.addr       = (w_wr_phase || (r_state == StRdWait)) ? {16'h0000, r_addr} : '0;
    bus.din        = w_wr_phase ? r_data : '0;
    bus.debug      = ~r_run;
    bus.cpu_clk_en = r_run || (r_state == StStepPulse);
  end

  assign bus.tx_data  = w_tx_data;
  assign bus.tx_valid = w_tx_valid;

  sdu_tx_ser u_tx_ser (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_tx_load),
    .i_one   (w_tx_one),
    .i_word  (w_tx_word),
    .i_ready (bus.tx_ready),
    .o_data  (w_tx_data),
    .o_valid (w_tx_valid),
    .o_done  (w_tx_done)
  );
endmodule
